// File: rtl/alu_vec_driver.sv
// Vector replay/check engine for registered ALU DUTs: buffers host-loaded vectors,
// drives each one for HOLD cycles, scores the DUT response and keeps run statistics.
module alu_vec_driver #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned OP_W  = 4,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned HOLD  = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic [OP_W-1:0]          ld_op,
  input  logic [WIDTH-1:0]         ld_a,
  input  logic [WIDTH-1:0]         ld_b,
  input  logic [WIDTH-1:0]         ld_exp_y,
  input  logic [2:0]               ld_exp_flags,
  output logic [OP_W-1:0]          dut_op,
  output logic [WIDTH-1:0]         dut_a,
  output logic [WIDTH-1:0]         dut_b,
  input  logic [WIDTH-1:0]         dut_y,
  input  logic                     dut_z,
  input  logic                     dut_c,
  input  logic                     dut_v,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     busy,
  output logic                     done,
  output logic [CNT_W-1:0]         pass_cnt,
  output logic [CNT_W-1:0]         fail_cnt,
  output logic [CNT_W-1:0]         first_fail_idx
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned HW = $clog2(HOLD);
  localparam int unsigned DW = OP_W + 2 * WIDTH;
  localparam int unsigned EW = DW + WIDTH + 3;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;

  logic [EW-1:0]     mem [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q, rd_ptr_nxt;
  logic [CW-1:0]     count_q;
  logic [HW-1:0]     hold_q;

  logic [DW-1:0]     drive_q, drive_d;
  logic [CNT_W-1:0]  pass_q, fail_q, first_fail_q, run_idx_q;

  logic [EW-1:0]     ld_entry, head;
  logic [DW-1:0]     ld_drive, head_drive, next_drive;
  logic [WIDTH-1:0]  head_exp_y;
  logic [2:0]        head_exp_flags;

  logic              in_idle, in_run;
  logic              push, start_run, run_nonempty, run_abort;
  logic              hold_last, score, last_pop, match;

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  assign in_idle  = (state_q == StIdle);
  assign in_run   = (state_q == StRun);

  assign ld_ready = in_idle && (count_q < CW'(DEPTH));
  assign push     = ld_valid && ld_ready;

  assign ld_drive = {ld_op, ld_a, ld_b};
  assign ld_entry = {ld_drive, ld_exp_y, ld_exp_flags};

  assign rd_ptr_nxt     = rd_ptr_q + 1'b1;
  assign head           = mem[rd_ptr_q];
  assign head_drive     = head[EW-1 -: DW];
  assign head_exp_y     = head[WIDTH+2 -: WIDTH];
  assign head_exp_flags = head[2:0];
  assign next_drive     = mem[rd_ptr_nxt][EW-1 -: DW];

  // Abort beats start, so a simultaneous pair in IDLE does nothing.
  assign start_run    = in_idle && start && !abort;
  assign run_nonempty = (count_q != '0) || push;
  assign run_abort    = in_run && abort;

  assign hold_last = in_run && (hold_q == HW'(HOLD - 1));
  assign score     = hold_last && !run_abort;
  assign last_pop  = score && (count_q == CW'(1));

  assign match = (dut_y == head_exp_y) && ({dut_z, dut_c, dut_v} == head_exp_flags);

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (start_run) state_d = run_nonempty ? StRun : StDone;
      end
      StRun: begin
        if (run_abort)     state_d = StIdle;
        else if (last_pop) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Vector FIFO
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= ld_entry;
    end
  end

  // Push only happens in IDLE and pop only in RUN, so they never coincide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (run_abort) begin
      rd_ptr_q <= wr_ptr_q;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
        count_q  <= count_q + 1'b1;
      end
      if (score) begin
        rd_ptr_q <= rd_ptr_nxt;
        count_q  <= count_q - 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // DUT drive and hold timing
  // ---------------------------------------------------------------------------
  always_comb begin
    drive_d = '0;
    if (start_run) begin
      // An entry pushed alongside start into an empty FIFO comes straight from the load port.
      if (run_nonempty) drive_d = (count_q == '0) ? ld_drive : head_drive;
    end else if (in_run && !run_abort) begin
      if (!score)         drive_d = drive_q;
      else if (!last_pop) drive_d = next_drive;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drive_q <= '0;
      hold_q  <= '0;
    end else begin
      drive_q <= drive_d;
      if (start_run || hold_last) begin
        hold_q <= '0;
      end else if (in_run) begin
        hold_q <= hold_q + 1'b1;
      end
    end
  end

  assign {dut_op, dut_a, dut_b} = drive_q;

  // ---------------------------------------------------------------------------
  // Statistics (all saturating)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_q       <= '0;
      fail_q       <= '0;
      first_fail_q <= '1;
      run_idx_q    <= '0;
    end else if (start_run) begin
      pass_q       <= '0;
      fail_q       <= '0;
      first_fail_q <= '1;
      run_idx_q    <= '0;
    end else if (score) begin
      if (run_idx_q != '1) run_idx_q <= run_idx_q + 1'b1;
      if (match) begin
        if (pass_q != '1) pass_q <= pass_q + 1'b1;
      end else begin
        if (fail_q != '1) fail_q <= fail_q + 1'b1;
        if (fail_q == '0) first_fail_q <= run_idx_q;
      end
    end
  end

  assign count          = count_q;
  assign busy           = in_run;
  assign done           = (state_q == StDone);
  assign pass_cnt       = pass_q;
  assign fail_cnt       = fail_q;
  assign first_fail_idx = first_fail_q;

endmodule

// File: tb/tb_alu_vec_driver.sv
// Self-checking bench for alu_vec_driver: a registered reference ALU acts as the DUT and a
// queue-based model predicts drive sequences, done timing and statistics.
module tb_alu_vec_driver;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned OP_W  = 4;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned HOLD  = 2;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] ey;
    logic [2:0]  ef;
  } vec_t;

  logic              clk, rst_n, start, abort, ld_valid, ld_ready;
  logic [OP_W-1:0]   ld_op, dut_op;
  logic [WIDTH-1:0]  ld_a, ld_b, ld_exp_y, dut_a, dut_b, dut_y;
  logic [2:0]        ld_exp_flags;
  logic              dut_z, dut_c, dut_v, busy, done;
  logic [CW-1:0]     count;
  logic [CNT_W-1:0]  pass_cnt, fail_cnt, first_fail_idx;

  vec_t vq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  alu_vec_driver #(
    .WIDTH(WIDTH), .OP_W(OP_W), .DEPTH(DEPTH), .HOLD(HOLD), .CNT_W(CNT_W)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_op(ld_op), .ld_a(ld_a), .ld_b(ld_b),
    .ld_exp_y(ld_exp_y), .ld_exp_flags(ld_exp_flags),
    .dut_op(dut_op), .dut_a(dut_a), .dut_b(dut_b),
    .dut_y(dut_y), .dut_z(dut_z), .dut_c(dut_c), .dut_v(dut_v),
    .count(count), .busy(busy), .done(done),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .first_fail_idx(first_fail_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU: 0 add, 1 sub (c = borrow), 2 and, 3 or, 4 xor, others pass a.
  function automatic logic [18:0] alu_ref(input logic [3:0] op, input logic [15:0] a,
                                          input logic [15:0] b);
    logic [16:0] s;
    logic [15:0] y;
    logic        c, v;
    c = 1'b0;
    v = 1'b0;
    case (op)
      4'd0: begin
        s = {1'b0, a} + {1'b0, b};
        y = s[15:0];
        c = s[16];
        v = (a[15] == b[15]) && (y[15] != a[15]);
      end
      4'd1: begin
        y = a - b;
        c = (a < b);
        v = (a[15] != b[15]) && (y[15] != a[15]);
      end
      4'd2:    y = a & b;
      4'd3:    y = a | b;
      4'd4:    y = a ^ b;
      default: y = a;
    endcase
    return {y, (y == 16'd0), c, v};
  endfunction

  // Registered ALU standing in for the device under drive (one cycle of latency).
  always @(posedge clk) {dut_y, dut_z, dut_c, dut_v} <= alu_ref(dut_op, dut_a, dut_b);

  function automatic vec_t mk(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                              input logic [15:0] ey, input logic [2:0] ef);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.ey = ey; v.ef = ef;
    return v;
  endfunction

  task automatic make_vec(output vec_t v, input bit bad_y, input bit bad_f);
    logic [18:0] r;
    v.op = 4'($urandom_range(0, 7));
    v.a  = 16'($urandom);
    v.b  = 16'($urandom);
    if ($urandom_range(0, 3) == 0) v.b = v.a;
    r    = alu_ref(v.op, v.a, v.b);
    v.ey = bad_y ? r[18:3] + 16'd1 : r[18:3];
    v.ef = bad_f ? r[2:0] ^ 3'(1 << $urandom_range(0, 2)) : r[2:0];
  endtask

  // Statistics the engine should report after scoring the first `upto` queued vectors.
  task automatic model_stats(input int upto, output int p, output int f, output int ffi);
    logic [18:0] r;
    p = 0; f = 0; ffi = 'hFFFF;
    for (int i = 0; i < upto; i++) begin
      r = alu_ref(vq[i].op, vq[i].a, vq[i].b);
      if (r == {vq[i].ey, vq[i].ef}) p++;
      else begin
        if (f == 0) ffi = i;
        f++;
      end
    end
  endtask

  // All stimulus tasks start and end 1 time unit after a rising edge.
  task automatic push_vec(input vec_t v);
    ld_valid = 1'b1; ld_op = v.op; ld_a = v.a; ld_b = v.b; ld_exp_y = v.ey; ld_exp_flags = v.ef;
    @(posedge clk); #1;
    ld_valid = 1'b0;
    if (vq.size() < DEPTH) vq.push_back(v);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Returns the cycle (1 = next sampled cycle) in which done is seen, or -1 on timeout.
  task automatic wait_done(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        cyc = i;
        return;
      end
    end
  endtask

  task automatic test_reset();
    #12;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %0b want 0", done); end
    n_checks++; if (count !== '0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
    n_checks++; if ({dut_op, dut_a, dut_b} !== '0) begin
      n_fail++; $display("FAIL reset_drive got %h/%h/%h want 0", dut_op, dut_a, dut_b);
    end
    n_checks++; if (pass_cnt !== '0 || fail_cnt !== '0) begin
      n_fail++; $display("FAIL reset_cnts got %0d/%0d want 0/0", pass_cnt, fail_cnt);
    end
    n_checks++; if (first_fail_idx !== 16'hFFFF) begin
      n_fail++; $display("FAIL reset_ffi got %h want ffff", first_fail_idx);
    end
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (ld_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %0b want 1", ld_ready); end
  endtask

  task automatic test_basic();
    logic [15:0] exp_a [5] = '{16'd1, 16'd1, 16'd3, 16'd3, 16'd0};
    vq.delete();
    push_vec(mk(4'd0, 16'd1, 16'd2, 16'd3, 3'b000));
    push_vec(mk(4'd1, 16'd3, 16'd1, 16'd2, 3'b000));
    pulse_start();
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      n_checks++; if (dut_a !== exp_a[c-1]) begin
        n_fail++; $display("FAIL basic_dut_a cycle %0d got %0d want %0d", c, dut_a, exp_a[c-1]);
      end
      n_checks++; if (done !== (c == 5)) begin
        n_fail++; $display("FAIL basic_done cycle %0d got %0b want %0b", c, done, c == 5);
      end
      n_checks++; if (busy !== (c < 5)) begin
        n_fail++; $display("FAIL basic_busy cycle %0d got %0b want %0b", c, busy, c < 5);
      end
    end
    n_checks++; if (pass_cnt !== 16'd2 || fail_cnt !== 16'd0 || first_fail_idx !== 16'hFFFF) begin
      n_fail++; $display("FAIL basic_stats got %0d/%0d/%h want 2/0/ffff",
                         pass_cnt, fail_cnt, first_fail_idx);
    end
    @(negedge clk);
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_len got 1 want 0"); end
    @(posedge clk); #1;
    vq.delete();
  endtask

  task automatic test_full();
    vec_t v;
    int   cyc, p, f, ffi;
    vq.delete();
    for (int i = 0; i < 17; i++) begin
      make_vec(v, i == 5, 1'b0);
      if (i == 16) begin
        n_checks++; if (ld_ready !== 1'b0 || count !== CW'(16)) begin
          n_fail++; $display("FAIL full_ready got ready=%0b count=%0d want 0/16", ld_ready, count);
        end
      end
      push_vec(v);
    end
    n_checks++; if (count !== CW'(16)) begin
      n_fail++; $display("FAIL full_overpush got count=%0d want 16", count);
    end
    pulse_start();
    wait_done(cyc);
    model_stats(vq.size(), p, f, ffi);
    n_checks++; if (cyc != 1 + 16 * HOLD) begin
      n_fail++; $display("FAIL full_done_cycle got %0d want %0d", cyc, 1 + 16 * HOLD);
    end
    n_checks++; if (pass_cnt !== 16'(p) || fail_cnt !== 16'(f) || first_fail_idx !== 16'(ffi)) begin
      n_fail++; $display("FAIL full_stats got %0d/%0d/%0d want %0d/%0d/%0d",
                         pass_cnt, fail_cnt, first_fail_idx, p, f, ffi);
    end
    n_checks++; if (count !== '0) begin n_fail++; $display("FAIL full_drain got %0d want 0", count); end
    @(posedge clk); #1;
    vq.delete();
  endtask

  task automatic test_flag_mismatch();
    int cyc, p, f, ffi;
    vq.delete();
    push_vec(mk(4'd0, 16'hFFFF, 16'd1, 16'd0, 3'b000));
    pulse_start();
    wait_done(cyc);
    model_stats(vq.size(), p, f, ffi);
    n_checks++; if (cyc != 1 + HOLD) begin
      n_fail++; $display("FAIL flag_done_cycle got %0d want %0d", cyc, 1 + HOLD);
    end
    n_checks++; if (fail_cnt !== 16'(f) || pass_cnt !== 16'(p) || first_fail_idx !== 16'(ffi)) begin
      n_fail++; $display("FAIL flag_stats got %0d/%0d/%0d want %0d/%0d/%0d",
                         pass_cnt, fail_cnt, first_fail_idx, p, f, ffi);
    end
    @(posedge clk); #1;
    vq.delete();
  endtask

  task automatic test_abort();
    vec_t v;
    int   p, f, ffi;
    vq.delete();
    for (int i = 0; i < 8; i++) begin
      make_vec(v, 1'b0, 1'b0);
      push_vec(v);
    end
    pulse_start();
    repeat (6) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    model_stats(3, p, f, ffi);
    @(negedge clk);
    n_checks++; if (busy !== 1'b0 || count !== '0) begin
      n_fail++; $display("FAIL abort_flush got busy=%0b count=%0d want 0/0", busy, count);
    end
    n_checks++; if (pass_cnt !== 16'(p) || fail_cnt !== 16'(f)) begin
      n_fail++; $display("FAIL abort_stats got %0d/%0d want %0d/%0d", pass_cnt, fail_cnt, p, f);
    end
    for (int c = 0; c < 8; c++) begin
      n_checks++; if (done !== 1'b0 || {dut_op, dut_a, dut_b} !== '0 || ld_ready !== 1'b1) begin
        n_fail++; $display("FAIL abort_quiet cycle %0d got done=%0b drive=%h ready=%0b want 0/0/1",
                           c, done, {dut_op, dut_a, dut_b}, ld_ready);
      end
      @(negedge clk);
    end
    @(posedge clk); #1;
    vq.delete();
  endtask

  task automatic test_empty_start();
    vq.delete();
    pulse_start();
    @(negedge clk);
    n_checks++; if (done !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL empty_done got done=%0b busy=%0b want 1/0", done, busy);
    end
    n_checks++; if (pass_cnt !== '0 || fail_cnt !== '0 || first_fail_idx !== 16'hFFFF) begin
      n_fail++; $display("FAIL empty_stats got %0d/%0d/%h want 0/0/ffff",
                         pass_cnt, fail_cnt, first_fail_idx);
    end
    @(negedge clk);
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL empty_done_len got 1 want 0"); end
    @(posedge clk); #1;
  endtask

  task automatic test_start_during_run();
    vec_t v;
    int   cyc, p, f, ffi;
    vq.delete();
    for (int i = 0; i < 3; i++) begin
      make_vec(v, i == 2, 1'b0);
      push_vec(v);
    end
    pulse_start();
    repeat (2) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(cyc);
    model_stats(3, p, f, ffi);
    n_checks++; if (cyc < 0 || cyc + 3 != 1 + 3 * HOLD) begin
      n_fail++; $display("FAIL restart_done_cycle got %0d want %0d", cyc + 3, 1 + 3 * HOLD);
    end
    n_checks++; if (pass_cnt !== 16'(p) || fail_cnt !== 16'(f) || first_fail_idx !== 16'(ffi)) begin
      n_fail++; $display("FAIL restart_stats got %0d/%0d/%0d want %0d/%0d/%0d",
                         pass_cnt, fail_cnt, first_fail_idx, p, f, ffi);
    end
    @(posedge clk); #1;
    vq.delete();
  endtask

  task automatic test_abort_start();
    vec_t v;
    int   cyc, p, f, ffi;
    vq.delete();
    make_vec(v, 1'b0, 1'b1);
    push_vec(v);
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_checks++; if (busy !== 1'b0 || done !== 1'b0 || count !== CW'(1)) begin
        n_fail++; $display("FAIL abort_start cycle %0d got busy=%0b done=%0b count=%0d want 0/0/1",
                           c, busy, done, count);
      end
    end
    @(posedge clk); #1;
    pulse_start();
    wait_done(cyc);
    model_stats(1, p, f, ffi);
    n_checks++; if (cyc != 1 + HOLD || fail_cnt !== 16'(f) || pass_cnt !== 16'(p)) begin
      n_fail++; $display("FAIL abort_start_run got cyc=%0d %0d/%0d want %0d %0d/%0d",
                         cyc, pass_cnt, fail_cnt, 1 + HOLD, p, f);
    end
    @(posedge clk); #1;
    vq.delete();
  endtask

  task automatic test_random();
    vec_t v;
    vec_t cur;
    int   n, p, f, ffi, r;
    for (int run = 0; run < 6; run++) begin
      vq.delete();
      n = $urandom_range(1, DEPTH);
      for (int i = 0; i < n; i++) begin
        r = $urandom_range(0, 5);
        make_vec(v, r == 0, r == 1);
        push_vec(v);
      end
      model_stats(n, p, f, ffi);
      pulse_start();
      for (int c = 1; c <= n * HOLD + 1; c++) begin
        @(negedge clk);
        if (c <= n * HOLD) begin
          cur = vq[(c - 1) / HOLD];
          n_checks++; if (dut_op !== cur.op || dut_a !== cur.a || dut_b !== cur.b) begin
            n_fail++; $display("FAIL rand_drive run %0d cycle %0d got %h/%h/%h want %h/%h/%h", run,
                               c, dut_op, dut_a, dut_b, cur.op, cur.a, cur.b);
          end
        end
        n_checks++; if (done !== (c == n * HOLD + 1)) begin
          n_fail++; $display("FAIL rand_done run %0d cycle %0d got %0b", run, c, done);
        end
      end
      n_checks++; if (pass_cnt !== 16'(p) || fail_cnt !== 16'(f) || first_fail_idx !== 16'(ffi)) begin
        n_fail++; $display("FAIL rand_stats run %0d got %0d/%0d/%0d want %0d/%0d/%0d", run,
                           pass_cnt, fail_cnt, first_fail_idx, p, f, ffi);
      end
      @(posedge clk); #1;
    end
    vq.delete();
  endtask

  task automatic test_reset_mid_run();
    vec_t v;
    vq.delete();
    for (int i = 0; i < 4; i++) begin
      make_vec(v, i == 0, 1'b0);
      push_vec(v);
    end
    pulse_start();
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    n_checks++; if ({dut_op, dut_a, dut_b} !== '0 || busy !== 1'b0 || count !== '0) begin
      n_fail++; $display("FAIL rstmid_state got drive=%h busy=%0b count=%0d want 0/0/0",
                         {dut_op, dut_a, dut_b}, busy, count);
    end
    n_checks++; if (pass_cnt !== '0 || fail_cnt !== '0 || first_fail_idx !== 16'hFFFF) begin
      n_fail++; $display("FAIL rstmid_stats got %0d/%0d/%h want 0/0/ffff",
                         pass_cnt, fail_cnt, first_fail_idx);
    end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rstmid_done got 1 want 0"); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (ld_ready !== 1'b1 || count !== '0) begin
      n_fail++; $display("FAIL rstmid_ready got ready=%0b count=%0d want 1/0", ld_ready, count);
    end
    vq.delete();
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; ld_valid = 1'b0;
    ld_op = '0; ld_a = '0; ld_b = '0; ld_exp_y = '0; ld_exp_flags = '0;
    test_reset();
    test_basic();
    test_full();
    test_flag_mismatch();
    test_abort();
    test_empty_start();
    test_start_during_run();
    test_abort_start();
    test_random();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/alu_vec_driver.md
Name: alu_vec_driver

Overview:
- Synthesizable stimulus/check engine for registered ALU DUTs (alu16 class), generalising the two-vector hand-driven bench to parametrised width, vector depth and hold time.
- Host loads vectors (op, a, b, expected y, expected flags) into an internal FIFO, then pulses start.
- Block replays each vector to the DUT for HOLD cycles, samples the response, compares it to the expected values, and keeps pass/fail statistics.
- Sits between the RL stimulus host and the DUT in emulation and simulation.

Parameters:
- WIDTH, 16: operand/result width.
- OP_W, 4: opcode width.
- DEPTH, 16: vector FIFO entries. Power of two, >=2.
- HOLD, 2: cycles each vector is driven. Must be >=2, because the DUT has one registered cycle of latency.
- CNT_W, 16: width of the statistics counters.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; begins a run.
- abort  in  1  single-cycle pulse; terminates a run.
- ld_valid  in  1  load request.
- ld_ready  out  1  load can be accepted.
- ld_op  in  OP_W  vector opcode.
- ld_a  in  WIDTH  vector operand a.
- ld_b  in  WIDTH  vector operand b.
- ld_exp_y  in  WIDTH  expected result.
- ld_exp_flags  in  3  expected flags {z,c,v}.
- dut_op  out  OP_W  opcode driven to DUT (registered).
- dut_a  out  WIDTH  operand a driven to DUT (registered).
- dut_b  out  WIDTH  operand b driven to DUT (registered).
- dut_y  in  WIDTH  DUT result.
- dut_z  in  1  DUT zero flag.
- dut_c  in  1  DUT carry flag.
- dut_v  in  1  DUT overflow flag.
- count  out  $clog2(DEPTH)+1  FIFO occupancy.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse at end of run.
- pass_cnt  out  CNT_W  vectors that matched.
- fail_cnt  out  CNT_W  vectors that mismatched.
- first_fail_idx  out  CNT_W  run-order index of the first mismatch.

Behaviour:
- Reset (async assert, sync release):
  - state IDLE, FIFO empty.
  - dut_*, count, busy, done, pass_cnt, fail_cnt all 0.
  - first_fail_idx all-ones.
- States: IDLE, RUN, DONE.
- Load:
  - ld_ready = (state==IDLE) && (count<DEPTH).
  - A push occurs when ld_valid && ld_ready.
  - ld_valid outside IDLE or when full is ignored and nothing is stored.
- IDLE -> RUN on start:
  - Clears pass_cnt and fail_cnt, sets first_fail_idx to all-ones, zeroes the run index.
  - A vector pushed in the same cycle as start is included in the run.
- Start with an empty FIFO: IDLE -> DONE; done pulses the next cycle; counters are 0.
- start outside IDLE is ignored.
- RUN timing, vector k (0-based):
  - dut_op/dut_a/dut_b hold the head entry during cycles 1+k*HOLD .. (k+1)*HOLD, where cycle 1 is the first RUN cycle.
  - The response is compared at the clock edge that ends the last hold cycle. The FIFO pops on that same edge.
- Compare rule:
  - Match iff dut_y==exp_y and {dut_z,dut_c,dut_v}==exp_flags.
  - Match: pass_cnt increments.
  - Mismatch: fail_cnt increments; first_fail_idx is loaded with the run index only if fail_cnt was 0.
  - Counters saturate at all-ones with no wrap. The run index also saturates.
- RUN -> DONE when the last entry pops.
  - The DONE cycle is 1+N*HOLD for N vectors; done is high for that cycle only.
  - DONE -> IDLE unconditionally.
  - dut_* return to 0 in DONE and IDLE.
- Abort while in RUN:
  - Next cycle: state IDLE, FIFO flushed (count=0), dut_*=0, no done pulse.
  - Counters hold values from completed compares; the in-flight vector is not scored.
  - Abort in IDLE or DONE has no effect.
- Abort and start in the same cycle: abort wins. From IDLE this means start is ignored.
- The FIFO is consumed by a run; the host reloads vectors to rerun.
- rst_n asserted mid-run forces every reset value immediately; no done pulse.

Test Plan:
- Load 2 vectors (op0,a=1,b=2,exp y=3 flags 000; op1,a=3,b=1,exp y=2 flags 000), HOLD=2, correct ALU DUT, start -> dut_a=1 in cycles 1-2, dut_a=3 in cycles 3-4, done at cycle 5, pass_cnt=2, fail_cnt=0, first_fail_idx=FFFF.
- Push 17 vectors while IDLE -> ld_ready low after the 16th push, count=16. Vector 5 has exp_y off by one -> after the run pass_cnt=15, fail_cnt=1, first_fail_idx=5.
- Vector op0,a=FFFF,b=1 with exp y=0 but exp_flags=000 (DUT gives z=1,c=1) -> fail_cnt=1 (flag-only mismatch detected).
- Load 8 vectors, start, pulse abort in cycle 7 (3 vectors scored) -> busy=0 and count=0 the next cycle, no done pulse, pass_cnt=3; dut_* stays 0 until the next start.
- start with an empty FIFO -> done high exactly one cycle later, pass_cnt=fail_cnt=0. start pulsed during RUN -> ignored; timing and counts unchanged.
- Drop rst_n mid-run between edges -> dut_*, busy, count, pass_cnt, fail_cnt go to 0 and first_fail_idx to all-ones without waiting for a clock edge. After release ld_ready=1.
